// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq_pkg: state encodings and ALU control constants shared by the ALU sequencer.
package alu_mul_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADD, S_DBL, S_EXEC, S_DONE} state_t;
    localparam logic [5:0] ALU_CTRL_ADD  = 6'b000010;
    localparam logic [5:0] ALU_CTRL_SUB  = 6'b010011;
    localparam logic [5:0] ALU_CTRL_IDLE = 6'b000000;
endpackage

// File: rtl/alu_mul_seq_alu.sv
// ALU: combinational Hack ALU (zero/negate x and y, add or and, optionally negate the result).
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] x1, x2, y1, y2, o;
    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        o   = f ? x2 + y2 : x2 & y2;
        out = no ? ~o : o;
    end
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: time-shares one Hack ALU for shift-and-add 16-bit multiply.
// Define ALU_SEQ_DIRECT_EN to add the single-pass DIRECT command (in_op=1, in_ctrl).
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int MUL_EARLY_EXIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [5:0]  in_ctrl,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_res,
    output logic        out_zr,
    output logic        out_ng
);
    localparam bit EARLY = MUL_EARLY_EXIT != 0;

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d, a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctrl;
`ifdef ALU_SEQ_DIRECT_EN
    logic [5:0]  ctrl_q, ctrl_d;
`else
    logic        unused_direct;
    assign unused_direct = ^{in_op, in_ctrl};
`endif

    ALU u_alu (
        .x(alu_x), .y(alu_y),
        .zx(alu_ctrl[5]), .nx(alu_ctrl[4]), .zy(alu_ctrl[3]),
        .ny(alu_ctrl[2]), .f(alu_ctrl[1]), .no(alu_ctrl[0]),
        .out(alu_out)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        cnt_d    = cnt_q;
        alu_x    = '0;
        alu_y    = '0;
        alu_ctrl = ALU_CTRL_IDLE;
`ifdef ALU_SEQ_DIRECT_EN
        ctrl_d   = ctrl_q;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                acc_d   = '0;
                a_sh_d  = in_a;
                b_sh_d  = in_b;
                cnt_d   = '0;
                state_d = in_b == '0 ? S_DONE : in_b[0] ? S_ADD : S_DBL;
`ifdef ALU_SEQ_DIRECT_EN
                ctrl_d  = in_ctrl;
                if (in_op) state_d = S_EXEC;
`endif
            end
            S_ADD: begin
                alu_x    = acc_q;
                alu_y    = a_sh_q;
                alu_ctrl = ALU_CTRL_ADD;
                acc_d    = alu_out;
                // cnt_q is the index of the multiplier bit now in b_sh_q[0]
                state_d  = ((EARLY && b_sh_q[15:1] == '0) || cnt_q == 4'd15) ? S_DONE : S_DBL;
            end
            S_DBL: begin
                alu_x    = a_sh_q;
                alu_y    = a_sh_q;
                alu_ctrl = ALU_CTRL_ADD;
                a_sh_d   = alu_out;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                state_d  = ((EARLY && b_sh_d == '0) || (!b_sh_d[0] && cnt_d == 4'd15)) ? S_DONE :
                           b_sh_d[0] ? S_ADD : S_DBL;
            end
`ifdef ALU_SEQ_DIRECT_EN
            S_EXEC: begin
                alu_x    = a_sh_q;
                alu_y    = b_sh_q;
                alu_ctrl = ctrl_q;
                acc_d    = alu_out;
                state_d  = S_DONE;
            end
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
`ifdef ALU_SEQ_DIRECT_EN
            ctrl_q  <= ALU_CTRL_IDLE;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SEQ_DIRECT_EN
            ctrl_q  <= ctrl_d;
`endif
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign out_res   = out_valid ? acc_q : '0;
    assign out_zr    = out_valid && acc_q == '0;
    assign out_ng    = out_valid && acc_q[15];
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench driving an early-exit and a full-walk instance with the same requests.
module tb_alu_mul_seq;
    logic        clk = 0, reset = 1, in_valid = 0, in_op = 0, out_ready = 1;
    logic [5:0]  in_ctrl = '0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [1:0]  rdy, vld, zr, ng;
    logic [15:0] res [2];

    typedef struct { logic [15:0] r; int le; int ln; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.MUL_EARLY_EXIT(1)) dut_e (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_op(in_op),
        .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .out_valid(vld[0]), .out_ready(out_ready),
        .out_res(res[0]), .out_zr(zr[0]), .out_ng(ng[0])
    );
    alu_mul_seq #(.MUL_EARLY_EXIT(0)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_op(in_op),
        .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b), .out_valid(vld[1]), .out_ready(out_ready),
        .out_res(res[1]), .out_zr(zr[1]), .out_ng(ng[1])
    );

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, g, act, expv);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        int idx = 0, cnt = 0;
        bit busy = 0, seen = 0, chk_idle = 0;
        logic [15:0] hold;
        exp_t e;
        always @(negedge clk) begin
            if (reset) begin
                busy = 0; seen = 0; chk_idle = 0; idx = q.size();
            end else begin
                if (busy) cnt++;
                if (chk_idle) begin
                    chk("in_ready_after_ack", g, rdy[g], 1);
                    chk_idle = 0;
                end
                if (vld[g]) begin
                    if (!busy || idx >= q.size()) begin
                        chk("unexpected_valid", g, busy && idx < q.size(), 1);
                    end else begin
                        e = q[idx];
                        if (!seen) begin
                            chk("latency", g, cnt, g == 0 ? e.le : e.ln);
                            chk("out_res", g, res[g], e.r);
                            chk("out_zr", g, zr[g], e.r == 16'h0);
                            chk("out_ng", g, ng[g], e.r[15]);
                            hold = res[g];
                            seen = 1;
                        end else begin
                            chk("stall_res", g, res[g], hold);
                            chk("stall_in_ready", g, rdy[g], 0);
                        end
                        if (out_ready) begin
                            idx++; busy = 0; seen = 0; chk_idle = 1;
                        end
                    end
                end
                if (in_valid && rdy[g] && !busy) begin
                    busy = 1; cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [5:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input int le, input int ln);
        int t = 0;
        while (rdy !== 2'b11 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        chk("in_ready_wait", 0, rdy, 2'b11);
        q.push_back('{r, le, ln});
        in_op = op; in_ctrl = c; in_a = a; in_b = b; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        for (int g = 0; g < 2; g++) begin
            chk("reset_in_ready", g, rdy[g], 1);
            chk("reset_out_valid", g, vld[g], 0);
            chk("reset_out_res", g, res[g], 0);
            chk("reset_out_zr", g, zr[g], 0);
            chk("reset_out_ng", g, ng[g], 0);
        end
        out_ready = 0;
        issue(0, 6'h0, 16'd3, 16'd5, 16'd15, 5, 18);
        t = 0;
        while (vld !== 2'b11 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        chk("stall_wait", 0, vld, 2'b11);
        repeat (10) @(posedge clk);
        #1 out_ready = 1;
        issue(0, 6'h0, 16'h1234, 16'h0000, 16'h0000, 1, 1);
        issue(0, 6'h0, 16'hFFFF, 16'hFFFF, 16'h0001, 32, 32);
        issue(0, 6'h0, 16'hFFFD, 16'h0007, 16'hFFEB, 6, 19);
        issue(0, 6'h0, 16'h0001, 16'h0001, 16'h0001, 2, 17);
        issue(0, 6'h0, 16'h8000, 16'h0002, 16'h0000, 3, 17);
`ifdef ALU_SEQ_DIRECT_EN
        issue(1, 6'b010011, 16'd10, 16'd3, 16'd7, 2, 2);
`else
        issue(1, 6'b010011, 16'd10, 16'd3, 16'd30, 4, 18);
`endif
        issue(0, 6'h0, 16'h00FF, 16'h0100, 16'hFF00, 10, 17);
        reset = 1;
        @(posedge clk); #1;
        chk("abort_in_ready", 0, rdy, 2'b11);
        chk("abort_out_valid", 0, vld, 2'b00);
        reset = 0;
        issue(0, 6'h0, 16'h00FF, 16'h0100, 16'hFF00, 10, 17);
        issue(0, 6'h0, 16'h0100, 16'h0100, 16'h0000, 10, 17);
        t = 0;
        while ((mon[0].idx != q.size() || mon[1].idx != q.size()) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("drain", 0, mon[0].idx + mon[1].idx, 2 * q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
